// File: rtl/ysyx_23060025_write_queue.sv
// rtl/ysyx_23060025_write_queue.sv - posted-write queue from D-cache/LSU to AXI4 AW/W/B channels
//
// Purpose: buffers byte/half/word stores and full cache-line write-backs in a
// DEPTH-entry circular FIFO. Entries drain in order, one AXI burst per entry.
// The head entry stays in the queue until its B response is accepted.
//
// Configuration macro: WQ_HAZARD_CHECK_EN
//   defined   - q_hit compares q_addr's line against every pending entry
//   undefined - q_hit = ~wq_empty (stall any read while writes are pending)
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   in_pwr_req/addr/data/strb/type, in_pwrdy   enqueue side (in_pwrdy = not full)
//   wq_empty              no entries, including the one in flight
//   q_addr, q_hit         line-address hazard query
//   wr_err                sticky non-OKAY B response flag
//   axi_addr_w_*          AW channel
//   axi_w_*               W channel
//   axi_bkwd_*            B channel
`ifndef MACRO_CACHE_LINE_OFF_ADDR_W
`define MACRO_CACHE_LINE_OFF_ADDR_W 4
`endif

module ysyx_23060025_write_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_OFF_W = `MACRO_CACHE_LINE_OFF_ADDR_W,
  parameter int DEPTH      = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_pwr_req,
  input  logic [ADDR_WIDTH-1:0]     in_pwaddr,
  input  logic [(8<<LINE_OFF_W)-1:0] in_pwdata,
  input  logic [3:0]                in_pwstrb,
  input  logic [2:0]                in_pwtype,
  output logic                      in_pwrdy,
  output logic                      wq_empty,
  input  logic [ADDR_WIDTH-1:0]     q_addr,
  output logic                      q_hit,
  output logic                      wr_err,
  output logic [ADDR_WIDTH-1:0]     axi_addr_w_addr_o,
  output logic                      axi_addr_w_valid_o,
  output logic [7:0]                axi_addr_w_len_o,
  output logic [2:0]                axi_addr_w_size_o,
  input  logic                      axi_addr_w_ready_i,
  output logic [DATA_WIDTH-1:0]     axi_w_data_o,
  output logic [3:0]                axi_w_strb_o,
  output logic                      axi_w_valid_o,
  output logic                      axi_w_last_o,
  input  logic                      axi_w_ready_i,
  input  logic                      axi_bkwd_valid_i,
  input  logic [1:0]                axi_bkwd_resp_i,
  output logic                      axi_bkwd_ready_o
);

  localparam int LINE_W = 8 << LINE_OFF_W;
  localparam int BEATS  = (1 << LINE_OFF_W) / 4;
  localparam int IW     = $clog2(DEPTH);
  localparam int PW     = IW + 1;
  localparam int BW     = (LINE_OFF_W - 2 > 1) ? (LINE_OFF_W - 2) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AW   = 2'd1;
  localparam logic [1:0] S_W    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  localparam logic [2:0] T_LINE = 3'b100;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [LINE_W-1:0]     data_mem [DEPTH];
  logic [3:0]            strb_mem [DEPTH];
  logic [2:0]            type_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [1:0]    state;
  logic [BW-1:0] beat;

  logic [IW-1:0]         head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [LINE_W-1:0]     head_data;
  logic [2:0]            head_type;
  logic                  head_is_line;
  logic                  do_enq, w_hs, b_hs;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign in_pwrdy = (count != PW'(DEPTH));
  assign wq_empty = (count == '0);
  assign do_enq   = in_pwr_req & in_pwrdy;

  assign head         = rd_ptr[IW-1:0];
  assign head_addr    = addr_mem[head];
  assign head_data    = data_mem[head];
  assign head_type    = type_mem[head];
  assign head_is_line = (head_type == T_LINE);

  assign axi_addr_w_valid_o = (state == S_AW);
  assign axi_addr_w_addr_o  = head_addr;
  assign axi_addr_w_len_o   = head_is_line ? 8'(BEATS - 1) : 8'd0;

  always_comb begin
    case (head_type)
      3'b000:  axi_addr_w_size_o = 3'd0;
      3'b001:  axi_addr_w_size_o = 3'd1;
      default: axi_addr_w_size_o = 3'd2;
    endcase
  end

  assign axi_w_valid_o = (state == S_W);
  assign axi_w_data_o  = head_data[beat*DATA_WIDTH +: DATA_WIDTH];
  assign axi_w_strb_o  = head_is_line ? 4'hF : strb_mem[head];
  assign axi_w_last_o  = (8'(beat) == axi_addr_w_len_o) && (state == S_W);

  assign axi_bkwd_ready_o = (state == S_B);

  assign w_hs = axi_w_valid_o & axi_w_ready_i;
  assign b_hs = axi_bkwd_valid_i & axi_bkwd_ready_o;

`ifdef WQ_HAZARD_CHECK_EN
  // Only entries between rd and wr are live; the in-flight head counts until
  // its B handshake. A same-cycle enqueue is not yet in count, so it is skipped.
  logic [IW-1:0] scan_idx;
  always_comb begin
    q_hit    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + IW'(k);
      if ((PW'(k) < count) &&
          (addr_mem[scan_idx][ADDR_WIDTH-1:LINE_OFF_W] == q_addr[ADDR_WIDTH-1:LINE_OFF_W]))
        q_hit = 1'b1;
    end
  end
`else
  logic unused_q_addr;
  assign unused_q_addr = ^q_addr;
  assign q_hit         = ~wq_empty;
`endif

  always_ff @(posedge clock) begin
    if (do_enq) begin
      addr_mem[wr_ptr[IW-1:0]] <= in_pwaddr;
      data_mem[wr_ptr[IW-1:0]] <= in_pwdata;
      strb_mem[wr_ptr[IW-1:0]] <= in_pwstrb;
      type_mem[wr_ptr[IW-1:0]] <= in_pwtype;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat   <= '0;
      wr_err <= 1'b0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (b_hs)   rd_ptr <= rd_ptr + PW'(1);
      case (state)
        S_IDLE: if (count != '0) state <= S_AW;
        S_AW: if (axi_addr_w_ready_i) begin
          state <= S_W;
          beat  <= '0;
        end
        S_W: if (w_hs) begin
          beat <= beat + BW'(1);
          if (axi_w_last_o) state <= S_B;
        end
        S_B: if (b_hs) begin
          if (axi_bkwd_resp_i != 2'b00) wr_err <= 1'b1;
          // count still includes the entry being retired here.
          state <= (count > PW'(1)) ? S_AW : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_write_queue.sv
// tb/tb_ysyx_23060025_write_queue.sv - directed table-driven bench for ysyx_23060025_write_queue
module tb_ysyx_23060025_write_queue;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_pwr_req;
  logic [31:0]  in_pwaddr;
  logic [127:0] in_pwdata;
  logic [3:0]   in_pwstrb;
  logic [2:0]   in_pwtype;
  logic         in_pwrdy, wq_empty, q_hit, wr_err;
  logic [31:0]  q_addr;
  logic [31:0]  aw_addr;
  logic         aw_valid, aw_ready;
  logic [7:0]   aw_len;
  logic [2:0]   aw_size;
  logic [31:0]  w_data;
  logic [3:0]   w_strb;
  logic         w_valid, w_last, w_ready;
  logic         b_valid, b_ready;
  logic [1:0]   b_resp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ysyx_23060025_write_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_OFF_W(4), .DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .in_pwr_req(in_pwr_req), .in_pwaddr(in_pwaddr), .in_pwdata(in_pwdata),
    .in_pwstrb(in_pwstrb), .in_pwtype(in_pwtype), .in_pwrdy(in_pwrdy),
    .wq_empty(wq_empty), .q_addr(q_addr), .q_hit(q_hit), .wr_err(wr_err),
    .axi_addr_w_addr_o(aw_addr), .axi_addr_w_valid_o(aw_valid),
    .axi_addr_w_len_o(aw_len), .axi_addr_w_size_o(aw_size),
    .axi_addr_w_ready_i(aw_ready),
    .axi_w_data_o(w_data), .axi_w_strb_o(w_strb), .axi_w_valid_o(w_valid),
    .axi_w_last_o(w_last), .axi_w_ready_i(w_ready),
    .axi_bkwd_valid_i(b_valid), .axi_bkwd_resp_i(b_resp), .axi_bkwd_ready_o(b_ready)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [3:0]   strb;
    logic [2:0]   typ;
    logic [7:0]   exp_len;
    logic [2:0]   exp_size;
    logic [3:0]   exp_strb;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enqueue(input logic [31:0] a, input logic [127:0] d,
                         input logic [3:0] s, input logic [2:0] t);
    in_pwr_req = 1'b1; in_pwaddr = a; in_pwdata = d; in_pwstrb = s; in_pwtype = t;
    tick();
    in_pwr_req = 1'b0;
  endtask

  task automatic wait_aw();
    int n = 0;
    while (!aw_valid && n < 20) begin tick(); n++; end
    check("aw_valid_timeout", aw_valid, 1'b1);
  endtask

  task automatic wait_w();
    int n = 0;
    while (!w_valid && n < 20) begin tick(); n++; end
    check("w_valid_timeout", w_valid, 1'b1);
  endtask

  // Runs one full AW/W/B transaction and checks every channel field.
  task automatic run_xact(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [127:0] d, input logic [3:0] strb, input logic [1:0] resp);
    int n;
    wait_aw();
    check("aw_addr", aw_addr, a);
    check("aw_len", aw_len, len);
    check("aw_size", aw_size, size);
    aw_ready = 1'b1;
    tick();
    aw_ready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wait_w();
      check("w_data", w_data, d[32*b +: 32]);
      check("w_strb", w_strb, strb);
      check("w_last", w_last, (b == int'(len)));
      w_ready = 1'b1;
      tick();
      w_ready = 1'b0;
    end
    n = 0;
    while (!b_ready && n < 20) begin tick(); n++; end
    check("b_ready_timeout", b_ready, 1'b1);
    b_valid = 1'b1; b_resp = resp;
    tick();
    b_valid = 1'b0; b_resp = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h8000_0010, {32'h44, 32'h33, 32'h22, 32'h11}, 4'h0, 3'b100, 8'd3, 3'd2, 4'hF};
    vecs[1] = '{32'h0000_1003, 128'hAB00_0000, 4'b1000, 3'b000, 8'd0, 3'd0, 4'h8};
    vecs[2] = '{32'h0000_2002, 128'h1234_0000, 4'b1100, 3'b001, 8'd0, 3'd1, 4'hC};
    vecs[3] = '{32'h0000_3000, 128'hDEAD_BEEF, 4'hF, 3'b010, 8'd0, 3'd2, 4'hF};
    vecs[4] = '{32'h0000_0040, {32'hA4A4_0004, 32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001},
                4'h5, 3'b100, 8'd3, 3'd2, 4'hF};

    reset = 1'b1; in_pwr_req = 1'b0; in_pwaddr = '0; in_pwdata = '0; in_pwstrb = '0;
    in_pwtype = '0; q_addr = '0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_in_pwrdy", in_pwrdy, 1'b1);
    check("rst_wq_empty", wq_empty, 1'b1);
    check("rst_q_hit", q_hit, 1'b0);
    check("rst_wr_err", wr_err, 1'b0);
    check("rst_valids", {aw_valid, w_valid, w_last, b_ready}, 4'b0000);

    // Single-entry transactions from the table.
    for (int i = 0; i < 5; i++) begin
      enqueue(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].typ);
      check("enq_not_empty", wq_empty, 1'b0);
      run_xact(vecs[i].addr, vecs[i].exp_len, vecs[i].exp_size, vecs[i].data, vecs[i].exp_strb, 2'b00);
      check("retired_empty", wq_empty, 1'b1);
      check("no_err", wr_err, 1'b0);
    end

    // Fill to full with all readies low; a 5th request must be dropped.
    for (int i = 0; i < 4; i++) begin
      check("fill_pwrdy", in_pwrdy, 1'b1);
      enqueue(32'h100 + 32'(4*i), 128'(32'hC0DE_0000 + i), 4'hF, 3'b010);
    end
    check("full_pwrdy", in_pwrdy, 1'b0);
    enqueue(32'h200, 128'hBAD, 4'hF, 3'b010);
    check("full_ignored_pwrdy", in_pwrdy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_xact(32'h100 + 32'(4*i), 8'd0, 3'd2, 128'(32'hC0DE_0000 + i), 4'hF, 2'b00);
      if (i == 0) check("pwrdy_after_first_b", in_pwrdy, 1'b1);
    end
    check("drained_empty", wq_empty, 1'b1);
    tick(); tick(); tick();
    check("no_5th_xact", aw_valid, 1'b0);

    // Hazard query with two pending entries.
    enqueue(32'h2000, 128'h1, 4'hF, 3'b010);
    enqueue(32'h2040, 128'h2, 4'hF, 3'b010);
    q_addr = 32'h2004; #1;
    check("q_hit_same_line", q_hit, 1'b1);
    q_addr = 32'h2044; #1;
    check("q_hit_second_entry", q_hit, 1'b1);
    q_addr = 32'h2020; #1;
`ifdef WQ_HAZARD_CHECK_EN
    check("q_hit_other_line", q_hit, 1'b0);
`else
    check("q_hit_other_line", q_hit, 1'b1);
`endif
    run_xact(32'h2000, 8'd0, 3'd2, 128'h1, 4'hF, 2'b00);
    q_addr = 32'h2004; #1;
`ifdef WQ_HAZARD_CHECK_EN
    check("q_hit_after_retire", q_hit, 1'b0);
`else
    check("q_hit_after_retire", q_hit, 1'b1);
`endif
    run_xact(32'h2040, 8'd0, 3'd2, 128'h2, 4'hF, 2'b00);
    check("q_hit_empty", q_hit, 1'b0);

    // SLVERR on the first of two entries.
    enqueue(32'h500, 128'h55, 4'hF, 3'b010);
    enqueue(32'h504, 128'h66, 4'h3, 3'b001);
    run_xact(32'h500, 8'd0, 3'd2, 128'h55, 4'hF, 2'b10);
    check("wr_err_set", wr_err, 1'b1);
    run_xact(32'h504, 8'd0, 3'd1, 128'h66, 4'h3, 2'b00);
    check("wr_err_sticky", wr_err, 1'b1);
    check("err_drained", wq_empty, 1'b1);

    // Reset while on W beat 2 of a line write-back.
    enqueue(32'h600, {32'h4, 32'h3, 32'h2, 32'h1}, 4'h0, 3'b100);
    wait_aw();
    aw_ready = 1'b1; tick(); aw_ready = 1'b0;
    wait_w();
    w_ready = 1'b1; tick(); w_ready = 1'b0;
    check("mid_beat2_data", w_data, 32'h2);
    reset = 1'b1;
    tick();
    check("rst_mid_valids", {aw_valid, w_valid, w_last, b_ready}, 4'b0000);
    check("rst_mid_empty", wq_empty, 1'b1);
    check("rst_mid_pwrdy", in_pwrdy, 1'b1);
    check("rst_mid_wr_err", wr_err, 1'b0);
    reset = 1'b0;
    tick(); tick();
    check("post_rst_idle", aw_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
